pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed single-stage writeback pipeline register.
- Carries a valid bit and a DATA_W payload through STAGES register slots.
- Supports downstream back-pressure (valid/ready), bubble collapsing, synchronous flush and an occupancy count.
- Used between any two processor pipeline stages (EX/MEM, MEM/WB, ...) where hazard logic must stall or squash in-flight instructions.

Parameters:
- DATA_W, 32, payload width in bits (control bits, rd, ALU result and read data concatenated by the instantiating stage).
- STAGES, 1, number of register slots in series; legal range 1..8.
- CNT_W, $clog2(STAGES+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock (single clock domain).
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents a transfer.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  valid bit of the last slot.
- out_data  out  DATA_W  payload of the last slot.
- out_ready  in  1  downstream consumes this cycle.
- flush  in  1  synchronous squash of all in-flight entries.
- count  out  CNT_W  number of valid slots.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, rst=1): all slot valid bits = 0, all slot payloads = 0. Outputs: out_valid=0, out_data=0, count=0, empty=1, in_ready=1 (when flush=0).
- Slots are numbered 0 (input side) to STAGES-1 (output side). out_valid and out_data come directly from slot STAGES-1, which is a registered output.
- Advance rule (combinational, evaluated from the output side back):
  - adv[STAGES] = out_ready.
  - Slot i may load when !valid[i] || adv[i+1].
  - Slot i loads from slot i-1, or from in_data for i=0.
  - A slot that does not load holds both its valid bit and its payload.
- in_ready = (!valid[0] || adv[1]) && !flush. This is a combinational path from out_ready and is documented as such.
- Transfer semantics:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - When out_valid=0, out_ready is don't-care.
- Payload regs load only when their slot loads and the incoming valid is 1. Bubbles do not overwrite payload, which saves toggling.
- Latency: with no stalls, in_data appears on out_data exactly STAGES cycles after acceptance. Throughput is 1 transfer/cycle.
- Bubble collapsing: an invalid slot always loads, so gaps close while the output is stalled. With out_ready=0 held, the block fills to STAGES entries and then in_ready=0.
- Ordering: strict FIFO order; no entry is duplicated or dropped except by flush.
- Flush (flush=1 at a clock edge):
  - Every valid bit becomes 0 and count becomes 0 on the next cycle.
  - in_ready=0 during the flush cycle, so the in_valid data is not accepted.
  - An out_valid/out_ready handshake in the flush cycle still counts as consumed by downstream. The block takes no special action.
  - Payload regs are not cleared.
- Simultaneous flush and rst: rst dominates.
- rst asserted mid-stall clears everything asynchronously. No state survives.
- count update: count_next = count + (in xfer) − (out xfer); 0 after flush. count never exceeds STAGES and never underflows.
- STAGES=1 degenerates to a one-entry register with hold and flush. in_ready = !valid || out_ready.
- No X propagation: valid bits must never be X after reset.

Decomposition:
- No shared-package content beyond a localparam for the max supported STAGES (8). DATA_W field layout stays in the instantiating stage.
- Natural sub-module: pipe_slot. It holds one valid bit and a DATA_W register with load and clear inputs, and is instantiated STAGES times in a generate loop.
- Ready chain and count logic stay in the top module.

Test Plan:
- Reset: rst=1 mid-run with 3 valid entries (STAGES=4) -> out_valid=0, out_data=0, count=0, empty=1 immediately without a clock edge. After release, in_ready=1.
- Streaming: STAGES=3, out_ready=1, in_data=1,2,3,... every cycle -> out_data=1 appears 3 cycles after its acceptance, then 2,3,... back-to-back. count stays at 3 once steady.
- Back-pressure and collapse: STAGES=4, out_ready=0, feed values with a 1-cycle gap (A, bubble, B, C, D) -> in_ready drops after 4 accepts and count=4. Raise out_ready -> A,B,C,D emerge on consecutive cycles.
- Flush: STAGES=2, both slots valid (0xAA, 0xBB), flush=1 with in_valid=1 and in_data=0xCC -> in_ready=0 that cycle. Next cycle count=0 and out_valid=0; 0xCC never appears on the output.
- Simultaneous in/out at full: STAGES=2, full, out_ready=1 and in_valid=1 -> in_ready=1, count stays 2, order preserved.
- STAGES=1 edge: DATA_W=8, alternate out_ready 0/1 with continuous in_valid -> no loss or duplication; a scoreboard matches the input sequence exactly.

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants for the elastic pipeline register.
package pipe_stage_elastic_pkg;

  localparam int MAX_STAGES = 8;

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One register slot of the elastic pipeline: a valid bit plus a payload register.
module pipe_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              next_valid,
  input  logic [DATA_W-1:0] next_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Bubbles never overwrite the payload, so an invalid load leaves data alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= next_valid;
      if (next_valid) begin
        data <= next_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with STAGES slots, bubble collapsing,
// synchronous flush and occupancy count. in_ready depends combinationally on out_ready.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("pipe_stage_elastic: STAGES must be in 1..%0d", MAX_STAGES);
  end

  logic [STAGES-1:0] valid;
  logic [DATA_W-1:0] data [STAGES];
  logic [STAGES:0]   adv;
  logic [CNT_W-1:0]  count_q;
  logic              in_xfer;
  logic              out_xfer;

  // Ready chain walks back from the output: a slot advances if it is empty or its successor advances.
  always_comb begin
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = !valid[i] || adv[i+1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic              slot_next_valid;
    logic [DATA_W-1:0] slot_next_data;

    if (i == 0) begin : g_head
      assign slot_next_valid = in_valid && !flush;
      assign slot_next_data  = in_data;
    end else begin : g_body
      assign slot_next_valid = valid[i-1];
      assign slot_next_data  = data[i-1];
    end

    pipe_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (adv[i]),
      .clear     (flush),
      .next_valid(slot_next_valid),
      .next_data (slot_next_data),
      .valid     (valid[i]),
      .data      (data[i])
    );
  end

  assign in_ready  = adv[0] && !flush;
  assign out_valid = valid[STAGES-1];
  assign out_data  = data[STAGES-1];

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // A downstream handshake during flush is still consumed; flush just zeroes the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic at STAGES = 4, 3, 2 and 1.
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        s4_in_valid = 0, s4_in_ready, s4_out_valid, s4_out_ready = 0, s4_flush = 0, s4_empty;
  logic [31:0] s4_in_data = '0, s4_out_data;
  logic [2:0]  s4_count;
  logic        s3_in_valid = 0, s3_in_ready, s3_out_valid, s3_out_ready = 0, s3_flush = 0, s3_empty;
  logic [31:0] s3_in_data = '0, s3_out_data;
  logic [1:0]  s3_count;
  logic        s2_in_valid = 0, s2_in_ready, s2_out_valid, s2_out_ready = 0, s2_flush = 0, s2_empty;
  logic [31:0] s2_in_data = '0, s2_out_data;
  logic [1:0]  s2_count;
  logic        s1_in_valid = 0, s1_in_ready, s1_out_valid, s1_out_ready = 0, s1_flush = 0, s1_empty;
  logic [7:0]  s1_in_data = '0, s1_out_data;
  logic [0:0]  s1_count;

  pipe_stage_elastic #(.DATA_W(32), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(s4_in_valid), .in_data(s4_in_data), .in_ready(s4_in_ready),
    .out_valid(s4_out_valid), .out_data(s4_out_data), .out_ready(s4_out_ready),
    .flush(s4_flush), .count(s4_count), .empty(s4_empty));

  pipe_stage_elastic #(.DATA_W(32), .STAGES(3)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(s3_in_valid), .in_data(s3_in_data), .in_ready(s3_in_ready),
    .out_valid(s3_out_valid), .out_data(s3_out_data), .out_ready(s3_out_ready),
    .flush(s3_flush), .count(s3_count), .empty(s3_empty));

  pipe_stage_elastic #(.DATA_W(32), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(s2_in_valid), .in_data(s2_in_data), .in_ready(s2_in_ready),
    .out_valid(s2_out_valid), .out_data(s2_out_data), .out_ready(s2_out_ready),
    .flush(s2_flush), .count(s2_count), .empty(s2_empty));

  pipe_stage_elastic #(.DATA_W(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_data(s1_in_data), .in_ready(s1_in_ready),
    .out_valid(s1_out_valid), .out_data(s1_out_data), .out_ready(s1_out_ready),
    .flush(s1_flush), .count(s1_count), .empty(s1_empty));

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] bp_data  [5] = '{32'hA1, 32'h0, 32'hB2, 32'hC3, 32'hD4};
  logic        bp_valid [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] drain_exp [3] = '{32'hB2, 32'hC3, 32'hD4};
  logic [23:0] rdy_pat = 24'b1011_0010_1110_0101_0011_0110;
  logic [7:0]  sb [$];
  logic [7:0]  next_val;
  logic [7:0]  exp_val;
  logic        exp_ready;

  initial begin
    // Reset, then load three entries into the 4-stage block and reset it mid-stall
    applyStimulus(2);
    rst = 1'b0;
    #1;
    checkOutput("s4_rst_out_valid", 32'(s4_out_valid), 32'd0);
    checkOutput("s4_rst_count", 32'(s4_count), 32'd0);
    checkOutput("s4_rst_empty", 32'(s4_empty), 32'd1);
    checkOutput("s4_rst_in_ready", 32'(s4_in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      s4_in_valid = 1'b1;
      s4_in_data  = 32'h11 * (k + 1);
      applyStimulus(1);
    end
    s4_in_valid = 1'b0;
    applyStimulus(2);
    checkOutput("s4_pre_count", 32'(s4_count), 32'd3);
    checkOutput("s4_pre_out_valid", 32'(s4_out_valid), 32'd1);
    checkOutput("s4_pre_out_data", s4_out_data, 32'h11);
    rst = 1'b1;
    #1;
    checkOutput("s4_async_out_valid", 32'(s4_out_valid), 32'd0);
    checkOutput("s4_async_out_data", s4_out_data, 32'd0);
    checkOutput("s4_async_count", 32'(s4_count), 32'd0);
    checkOutput("s4_async_empty", 32'(s4_empty), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("s4_release_in_ready", 32'(s4_in_ready), 32'd1);

    // Streaming through 3 stages at full rate
    applyStimulus(1);
    s3_out_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      s3_in_valid = 1'b1;
      s3_in_data  = 32'(c);
      #1;
      checkOutput($sformatf("s3_stream_in_ready_%0d", c), 32'(s3_in_ready), 32'd1);
      applyStimulus(1);
      checkOutput($sformatf("s3_stream_count_%0d", c), 32'(s3_count), (c < 3) ? 32'(c) : 32'd3);
      if (c >= 3) begin
        checkOutput($sformatf("s3_stream_out_valid_%0d", c), 32'(s3_out_valid), 32'd1);
        checkOutput($sformatf("s3_stream_out_data_%0d", c), s3_out_data, 32'(c - 2));
      end
    end
    s3_in_valid = 1'b0;
    for (int c = 9; c <= 10; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("s3_drain_out_data_%0d", c), s3_out_data, 32'(c - 2));
      checkOutput($sformatf("s3_drain_out_valid_%0d", c), 32'(s3_out_valid), 32'd1);
    end
    applyStimulus(1);
    checkOutput("s3_final_out_valid", 32'(s3_out_valid), 32'd0);
    checkOutput("s3_final_count", 32'(s3_count), 32'd0);
    checkOutput("s3_final_empty", 32'(s3_empty), 32'd1);

    // Back-pressure with a bubble in the input stream
    s4_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s4_in_valid = bp_valid[k];
      s4_in_data  = bp_data[k];
      #1;
      if (bp_valid[k]) begin
        checkOutput($sformatf("s4_bp_in_ready_%0d", k), 32'(s4_in_ready), 32'd1);
      end
      applyStimulus(1);
    end
    s4_in_valid = 1'b1;
    s4_in_data  = 32'hE5;
    #1;
    checkOutput("s4_full_in_ready", 32'(s4_in_ready), 32'd0);
    checkOutput("s4_full_count", 32'(s4_count), 32'd4);
    applyStimulus(1);
    checkOutput("s4_hold_count", 32'(s4_count), 32'd4);
    checkOutput("s4_hold_out_data", s4_out_data, 32'hA1);
    s4_in_valid  = 1'b0;
    s4_out_ready = 1'b1;
    #1;
    checkOutput("s4_release_out_valid", 32'(s4_out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("s4_drain_out_data_%0d", k), s4_out_data, drain_exp[k]);
      checkOutput($sformatf("s4_drain_out_valid_%0d", k), 32'(s4_out_valid), 32'd1);
    end
    applyStimulus(1);
    checkOutput("s4_drained_out_valid", 32'(s4_out_valid), 32'd0);
    checkOutput("s4_drained_count", 32'(s4_count), 32'd0);

    // Flush squashes both slots and refuses the concurrent input
    s2_out_ready = 1'b0;
    s2_in_valid  = 1'b1;
    s2_in_data   = 32'hAA;
    applyStimulus(1);
    s2_in_data   = 32'hBB;
    applyStimulus(1);
    s2_in_valid  = 1'b0;
    #1;
    checkOutput("s2_fill_count", 32'(s2_count), 32'd2);
    checkOutput("s2_fill_out_data", s2_out_data, 32'hAA);
    s2_flush     = 1'b1;
    s2_in_valid  = 1'b1;
    s2_in_data   = 32'hCC;
    s2_out_ready = 1'b1;
    #1;
    checkOutput("s2_flush_in_ready", 32'(s2_in_ready), 32'd0);
    applyStimulus(1);
    s2_flush    = 1'b0;
    s2_in_valid = 1'b0;
    #1;
    checkOutput("s2_flush_count", 32'(s2_count), 32'd0);
    checkOutput("s2_flush_out_valid", 32'(s2_out_valid), 32'd0);
    checkOutput("s2_flush_empty", 32'(s2_empty), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("s2_post_flush_out_valid_%0d", k), 32'(s2_out_valid), 32'd0);
    end

    // Simultaneous input and output transfer while full
    s2_out_ready = 1'b0;
    s2_in_valid  = 1'b1;
    s2_in_data   = 32'h11;
    applyStimulus(1);
    s2_in_data   = 32'h22;
    applyStimulus(1);
    s2_out_ready = 1'b1;
    s2_in_data   = 32'h33;
    #1;
    checkOutput("s2_full_in_ready", 32'(s2_in_ready), 32'd1);
    checkOutput("s2_full_count", 32'(s2_count), 32'd2);
    checkOutput("s2_full_out_data", s2_out_data, 32'h11);
    applyStimulus(1);
    checkOutput("s2_pass1_count", 32'(s2_count), 32'd2);
    checkOutput("s2_pass1_out_data", s2_out_data, 32'h22);
    s2_in_data = 32'h44;
    applyStimulus(1);
    checkOutput("s2_pass2_count", 32'(s2_count), 32'd2);
    checkOutput("s2_pass2_out_data", s2_out_data, 32'h33);
    s2_in_valid = 1'b0;
    applyStimulus(1);
    checkOutput("s2_pass3_count", 32'(s2_count), 32'd1);
    checkOutput("s2_pass3_out_data", s2_out_data, 32'h44);
    applyStimulus(1);
    checkOutput("s2_pass4_out_valid", 32'(s2_out_valid), 32'd0);
    checkOutput("s2_pass4_count", 32'(s2_count), 32'd0);

    // Single-slot register with toggling downstream ready, scoreboarded
    next_val = 8'd1;
    for (int c = 0; c < 24; c++) begin
      s1_out_ready = rdy_pat[c];
      s1_in_valid  = 1'b1;
      s1_in_data   = next_val;
      #1;
      exp_ready = (sb.size() == 0) || s1_out_ready;
      checkOutput($sformatf("s1_out_valid_%0d", c), 32'(s1_out_valid), (sb.size() != 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("s1_count_%0d", c), 32'(s1_count), 32'(sb.size()));
      checkOutput($sformatf("s1_in_ready_%0d", c), 32'(s1_in_ready), 32'(exp_ready));
      if (sb.size() != 0 && s1_out_ready) begin
        exp_val = sb.pop_front();
        checkOutput($sformatf("s1_out_data_%0d", c), 32'(s1_out_data), 32'(exp_val));
      end
      if (exp_ready) begin
        sb.push_back(next_val);
        next_val = next_val + 8'd1;
      end
      applyStimulus(1);
    end
    s1_in_valid  = 1'b0;
    s1_out_ready = 1'b1;
    #1;
    checkOutput("s1_drain_out_valid", 32'(s1_out_valid), (sb.size() != 0) ? 32'd1 : 32'd0);
    if (sb.size() != 0) begin
      exp_val = sb.pop_front();
      checkOutput("s1_drain_out_data", 32'(s1_out_data), 32'(exp_val));
    end
    applyStimulus(1);
    checkOutput("s1_final_out_valid", 32'(s1_out_valid), 32'd0);
    checkOutput("s1_final_empty", 32'(s1_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
